// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the display share arbiter:
//     state_e      - arbiter FSM states (IDLE, SHOW, RELEASE)
//     dwell_cycles - converts a dwell time in ns to a cycle count (at least 1)
//     cnt_width    - width of a down-counter that must hold values 0..dwell
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic int dwell_cycles(input int dwell_ns, input int period_ns);
    int c;
    c = dwell_ns / period_ns;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int cnt_width(input int dwell);
    return (dwell < 1) ? 1 : $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Purely combinational round-robin selector. Scans req_i starting at
//   ptr_i and wrapping; the first set bit wins.
// Ports:
//   req_i    [N-1:0]   request vector
//   ptr_i    [IW-1:0]  index with highest priority this cycle
//   onehot_o [N-1:0]   one-hot winner (zero when valid_o is low)
//   idx_o    [IW-1:0]  winner index (zero when valid_o is low)
//   valid_o            at least one request present
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int          pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int k = 0; k < N; k++) begin
      pos     = (int'(ptr_i) + k) % N;
      pos_idx = IW'(pos);
      if (!valid_o && req_i[pos_idx]) begin
        valid_o           = 1'b1;
        idx_o             = pos_idx;
        onehot_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// display_share_arbiter
//   Round-robin arbiter sharing one segment display among Requesters sources.
//   The winner owns the display for DwellCycles cycles, its value is driven
//   on Data, then Done pulses once and priority moves past the owner.
//
//   Handshake: a source raises Req[i] and holds it until it sees Done[i]
//   (normal end) or drops it early (abort: no Done is sent). Grant[i] is
//   high for exactly the cycles the display belongs to source i. Req is
//   ignored during the single RELEASE cycle; a Req still high afterwards is
//   arbitrated again as a fresh request.
//
//   Optional feature macro LIVE_DATA_EN: when defined, Data follows
//   ReqData[Owner] every SHOW cycle (1-cycle lag); when undefined, Data is
//   latched at grant and frozen for the dwell.
// Ports:
//   Clock       system clock, rising edge
//   Reset_n     synchronous active-low reset
//   Req         per-source request
//   ReqData     per-source offered value
//   Grant       one-hot owner, zero when idle
//   Done        one-cycle pulse to the owner at end of dwell
//   Data        value to the segment decoder
//   Busy        FSM is not IDLE
//   Owner       index of the current or last owner
//   DbgState_o  raw FSM state (display_pkg::state_e encoding)
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int ClockPeriod_ns = 20,
  parameter int Size           = 4,
  parameter int Requesters     = 3,
  parameter int DwellTime_ns   = 200,
  parameter int IdleValue      = 0
) (
  input  logic                                 Clock,
  input  logic                                 Reset_n,
  input  logic [Requesters-1:0]                Req,
  input  logic [Requesters-1:0][Size-1:0]      ReqData,
  output logic [Requesters-1:0]                Grant,
  output logic [Requesters-1:0]                Done,
  output logic [Size-1:0]                      Data,
  output logic                                 Busy,
  output logic [$clog2(Requesters)-1:0]        Owner,
  output logic [1:0]                           DbgState_o
);

  localparam int DWELL = dwell_cycles(DwellTime_ns, ClockPeriod_ns);
  localparam int CW    = cnt_width(DWELL);
  localparam int OW    = $clog2(Requesters);
  localparam logic [Size-1:0] IDLE_DATA = Size'(IdleValue);

  state_e                state_q;
  logic [Requesters-1:0] grant_q;
  logic [Requesters-1:0] done_q;
  logic [Size-1:0]       data_q;
  logic [OW-1:0]         owner_q;
  logic [OW-1:0]         ptr_q;
  logic [CW-1:0]         cnt_q;

  logic [Requesters-1:0] pick_onehot;
  logic [OW-1:0]         pick_idx;
  logic                  pick_valid;
  logic [OW-1:0]         owner_inc;

  rr_pick #(
    .N  (Requesters),
    .IW (OW)
  ) u_pick (
    .req_i    (Req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Priority after a grant ends starts just past the owner, wrapping.
  assign owner_inc = (owner_q == OW'(Requesters - 1)) ? '0 : owner_q + OW'(1);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= IDLE_DATA;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_onehot;
            data_q  <= ReqData[pick_idx];
            owner_q <= pick_idx;
            cnt_q   <= CW'(DWELL - 1);
            state_q <= SHOW;
          end
        end

        SHOW: begin
          if (!Req[owner_q]) begin
            // Owner withdrew: release immediately without a Done pulse.
            grant_q <= '0;
            data_q  <= IDLE_DATA;
            ptr_q   <= owner_inc;
            state_q <= IDLE;
          end else begin
`ifdef LIVE_DATA_EN
            data_q <= ReqData[owner_q];
`endif
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end else begin
              grant_q         <= '0;
              done_q          <= '0;
              done_q[owner_q] <= 1'b1;
              state_q         <= RELEASE;
            end
          end
        end

        RELEASE: begin
          done_q  <= '0;
          data_q  <= IDLE_DATA;
          ptr_q   <= owner_inc;
          state_q <= IDLE;
        end

        default: begin
          grant_q <= '0;
          done_q  <= '0;
          data_q  <= IDLE_DATA;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Grant      = grant_q;
  assign Done       = done_q;
  assign Data       = data_q;
  assign Busy       = (state_q != IDLE);
  assign Owner      = owner_q;
  assign DbgState_o = state_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter with Requesters=3, Size=4, 20 ns clock,
// 200 ns dwell (10 cycles). Vectors carry per-cycle inputs and the outputs
// expected right after the edge that samples them.
module tb_display_share_arbiter;

  logic            Clock;
  logic            Reset_n;
  logic [2:0]      Req;
  logic [2:0][3:0] ReqData;
  logic [2:0]      Grant;
  logic [2:0]      Done;
  logic [3:0]      Data;
  logic            Busy;
  logic [1:0]      Owner;
  logic [1:0]      DbgState;

  display_share_arbiter #(
    .ClockPeriod_ns (20),
    .Size           (4),
    .Requesters     (3),
    .DwellTime_ns   (200),
    .IdleValue      (0)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Req        (Req),
    .ReqData    (ReqData),
    .Grant      (Grant),
    .Done       (Done),
    .Data       (Data),
    .Busy       (Busy),
    .Owner      (Owner),
    .DbgState_o (DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  // ---------------- vector table ----------------
  // exp packs {grant[2:0], done[2:0], data[3:0], busy, owner[1:0]}
  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] rd;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  int          n_vec;
  int          n_fail;

  function automatic logic [12:0] pk(input logic [2:0] g, input logic [2:0] d,
                                     input logic [3:0] data, input logic busy,
                                     input logic [1:0] owner);
    return {g, d, data, busy, owner};
  endfunction

  function automatic logic [11:0] mkrd(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic add(input logic rst_n, input logic [2:0] req,
                     input logic [11:0] rd, input logic [12:0] exp);
    vec_t v;
    v.rst_n = rst_n;
    v.req   = req;
    v.rd    = rd;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic apply(input vec_t v, input int idx);
    logic [12:0] got;
    logic [12:0] exp;
    @(negedge Clock);
    Reset_n = v.rst_n;
    Req     = v.req;
    ReqData = v.rd;
    exp_q.push_back(v.exp);
    @(posedge Clock);
    #1;
    got = {Grant, Done, Data, Busy, Owner};
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec[%0d] grant/done/data/busy/owner got %b/%b/%h/%b/%0d want %b/%b/%h/%b/%0d",
               idx, got[12:10], got[9:7], got[6:3], got[2], got[1:0],
               exp[12:10], exp[9:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    logic [3:0]  val [3];
    logic [11:0] rd;
    logic [3:0]  live9;

    n_vec   = 0;
    n_fail  = 0;
    Reset_n = 1'b0;
    Req     = '0;
    ReqData = '0;

    // Reset held for two edges with all requests high.
    add(0, 3'b111, 12'hFFF, pk(0, 0, 0, 0, 0));
    add(0, 3'b111, 12'hFFF, pk(0, 0, 0, 0, 0));

    // Single request from source 1, value 5, held until Done.
    // Non-owner data is don't-care and randomised.
    for (int c = 0; c < 10; c++)
      add(1, 3'b010, mkrd(4'($urandom_range(0, 15)), 4'h5, 4'($urandom_range(0, 15))),
          pk(3'b010, 0, 4'h5, 1, 1));
    add(1, 3'b010, mkrd(4'h0, 4'h5, 4'h0), pk(0, 3'b010, 4'h5, 1, 1));
    add(1, 3'b000, mkrd(4'h0, 4'h5, 4'h0), pk(0, 0, 0, 0, 1));
    add(1, 3'b000, mkrd(4'h0, 4'h5, 4'h0), pk(0, 0, 0, 0, 1));

    // Pointer now sits at 2; only source 1 asks, so it wins. Then reset mid-SHOW.
    add(1, 3'b010, mkrd(4'h0, 4'h6, 4'h0), pk(3'b010, 0, 4'h6, 1, 1));
    add(0, 3'b010, mkrd(4'h0, 4'h6, 4'h0), pk(0, 0, 0, 0, 0));

    // All three held continuously: 0,1,2 in turn, 10 grant cycles each, 12-cycle period.
    val[0] = 4'h3; val[1] = 4'h7; val[2] = 4'hE;
    rd = mkrd(val[0], val[1], val[2]);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 10; c++)
        add(1, 3'b111, rd, pk(3'(1 << r), 0, val[r], 1, 2'(r)));
      add(1, 3'b111, rd, pk(0, 3'(1 << r), val[r], 1, 2'(r)));
      add(1, 3'b111, rd, pk(0, 0, 0, 0, 2'(r)));
    end
    add(1, 3'b000, rd, pk(0, 0, 0, 0, 2));

    // Source 2 aborts on its 5th sampled cycle (after 4 SHOW cycles).
    rd = mkrd(4'h1, 4'h2, 4'hB);
    for (int c = 0; c < 4; c++)
      add(1, 3'b100, rd, pk(3'b100, 0, 4'hB, 1, 2));
    add(1, 3'b001, rd, pk(0, 0, 0, 0, 2));
    // Next arbitration sees 0 and 2; pointer past 2 gives 0.
    add(1, 3'b101, rd, pk(3'b001, 0, 4'h1, 1, 0));
    // Owner 0 holds through Done while 1 also requests: 1 wins next.
    for (int c = 0; c < 9; c++)
      add(1, 3'b011, rd, pk(3'b001, 0, 4'h1, 1, 0));
    add(1, 3'b011, rd, pk(0, 3'b001, 4'h1, 1, 0));
    add(1, 3'b011, rd, pk(0, 0, 0, 0, 0));
    add(1, 3'b011, rd, pk(3'b010, 0, 4'h2, 1, 1));
    add(1, 3'b000, rd, pk(0, 0, 0, 0, 1));

    // Owner value changes 5 -> 9 mid-dwell (pointer now 2).
`ifdef LIVE_DATA_EN
    live9 = 4'h9;
`else
    live9 = 4'h5;
`endif
    for (int c = 0; c < 3; c++)
      add(1, 3'b100, mkrd(4'h0, 4'h0, 4'h5), pk(3'b100, 0, 4'h5, 1, 2));
    for (int c = 3; c < 10; c++)
      add(1, 3'b100, mkrd(4'h0, 4'h0, 4'h9), pk(3'b100, 0, live9, 1, 2));
    add(1, 3'b100, mkrd(4'h0, 4'h0, 4'h9), pk(0, 3'b100, live9, 1, 2));
    add(1, 3'b000, mkrd(4'h0, 4'h0, 4'h9), pk(0, 0, 0, 0, 2));
    add(1, 3'b000, mkrd(4'h0, 4'h0, 4'h9), pk(0, 0, 0, 0, 2));

    foreach (vecs[i]) apply(vecs[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
